// File: rtl/video_pkg.sv
// video_pkg: pattern codes and colour-bar table shared by the pattern generator.
package video_pkg;
   typedef enum logic [1:0] {
      PAT_BARS = 2'd0,
      PAT_GRID = 2'd1,
      PAT_GRAD = 2'd2,
      PAT_MOVE = 2'd3
   } pat_e;
   localparam logic [23:0] BAR_COLORS [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };
endpackage

// File: rtl/video_timing_core.sv
// video_timing_core: raster counters plus registered sync, de, x/y and frame_start.
module video_timing_core #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
)(
   input  logic        clk_p,
   input  logic        ext_reset,
   input  logic        enable,
   output logic [11:0] hcnt,
   output logic [11:0] vcnt,
   output logic        line_end,
   output logic        frame_end,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        frame_start,
   output logic [11:0] x,
   output logic [11:0] y
);
   localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [11:0] HS_ON  = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_OFF = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] VS_ON  = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_OFF = 12'(V_ACTIVE + V_FP + V_SYNC);
   logic active;
   assign line_end  = hcnt == H_LAST;
   assign frame_end = line_end && vcnt == V_LAST;
   assign active    = hcnt < 12'(H_ACTIVE) && vcnt < 12'(V_ACTIVE);
   always_ff @(posedge clk_p or negedge ext_reset)
      if (!ext_reset) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (!enable) begin
         hcnt <= '0;
         vcnt <= '0;
      end else begin
         hcnt <= line_end ? '0 : hcnt + 12'd1;
         if (line_end) vcnt <= frame_end ? '0 : vcnt + 12'd1;
      end
   // Outputs describe the counters of the previous cycle.
   always_ff @(posedge clk_p or negedge ext_reset)
      if (!ext_reset) begin
         hsync       <= !HS_POL;
         vsync       <= !VS_POL;
         de          <= 1'b0;
         frame_start <= 1'b0;
         x           <= '0;
         y           <= '0;
      end else begin
         hsync       <= (enable && hcnt >= HS_ON && hcnt < HS_OFF) ? HS_POL : !HS_POL;
         vsync       <= (enable && vcnt >= VS_ON && vcnt < VS_OFF) ? VS_POL : !VS_POL;
         de          <= enable && active;
         frame_start <= enable && hcnt == '0 && vcnt == '0;
         x           <= (enable && active) ? hcnt : '0;
         y           <= (enable && active) ? vcnt : '0;
      end
endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: VGA-style timing with bars/grid/gradient/moving-bar test patterns.
// Define VPG_MOVING_BAR_EN to build the moving bar for pattern 3; otherwise pattern 3 is black.
module video_pattern_gen
   import video_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
)(
   input  logic        clk_p,
   input  logic        ext_reset,
   input  logic        enable,
   input  logic [1:0]  pattern_sel,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b,
   output logic [11:0] x,
   output logic [11:0] y,
   output logic        frame_start,
   output logic [7:0]  frame_cnt
);
   localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);
   logic [11:0] hcnt, vcnt;
   logic        line_end, frame_end, active;
   pat_e        pat;
   logic [11:0] bar_px;
   logic [2:0]  bar_idx;
   logic [23:0] grid_rgb, grad_rgb, move_rgb, rgb_nxt;
   video_timing_core #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(HS_POL), .VS_POL(VS_POL)
   ) u_core (
      .clk_p(clk_p), .ext_reset(ext_reset), .enable(enable),
      .hcnt(hcnt), .vcnt(vcnt), .line_end(line_end), .frame_end(frame_end),
      .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start),
      .x(x), .y(y)
   );
   assign active   = hcnt < 12'(H_ACTIVE) && vcnt < 12'(V_ACTIVE);
   assign grid_rgb = (hcnt[4:0] == '0 || vcnt[4:0] == '0) ? 24'hFFFFFF : 24'h0;
   assign grad_rgb = {hcnt[7:0], vcnt[7:0], hcnt[7:0] + vcnt[7:0]};
`ifdef VPG_MOVING_BAR_EN
   logic [11:0] bar_left;
   assign bar_left = 12'({3'b0, frame_cnt, 1'b0} % 12'(H_ACTIVE));
   assign move_rgb = (hcnt >= bar_left && hcnt < bar_left + 12'd16) ? 24'hFFFFFF : 24'h0;
`else
   assign move_rgb = 24'h0;
`endif
   always_comb begin
      rgb_nxt = pat == PAT_BARS ? BAR_COLORS[bar_idx] :
                pat == PAT_GRID ? grid_rgb :
                pat == PAT_GRAD ? grad_rgb : move_rgb;
   end
   // Bar position tracks hcnt with a counter so no divider is needed.
   always_ff @(posedge clk_p or negedge ext_reset)
      if (!ext_reset) begin
         pat       <= PAT_BARS;
         frame_cnt <= '0;
         bar_px    <= '0;
         bar_idx   <= '0;
         {r, g, b} <= '0;
      end else begin
         if (!enable || frame_end) pat <= pat_e'(pattern_sel);
         if (enable && frame_end) frame_cnt <= frame_cnt + 8'd1;
         bar_px    <= (!enable || line_end || bar_px == BAR_LAST) ? '0 : bar_px + 12'd1;
         bar_idx   <= (!enable || line_end) ? '0 : bar_idx + 3'(bar_px == BAR_LAST);
         {r, g, b} <= (enable && active) ? rgb_nxt : 24'h0;
      end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: default horizontal timing, shortened vertical timing to keep frames short.
module tb_video_pattern_gen;
   localparam int HA = 640, HF = 16, HS = 96, HB = 48;
   localparam int VA = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
`ifdef VPG_MOVING_BAR_EN
   localparam logic [23:0] MW = 24'hFFFFFF;
`else
   localparam logic [23:0] MW = 24'h000000;
`endif
   typedef struct packed {
      logic [11:0] ex;
      logic [11:0] ey;
      logic [7:0]  fc;
      logic [23:0] rgb;
   } exp_t;
   logic        clk_p = 1'b0, ext_reset = 1'b0, enable = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic        hsync, vsync, de, frame_start;
   logic [7:0]  r, g, b, frame_cnt;
   logic [11:0] x, y;
   int          n_cmp = 0, n_bad = 0;
   exp_t        sb[$];
   string       sb_name[$];
   always #5 clk_p = ~clk_p;
   video_pattern_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut (
      .clk_p(clk_p), .ext_reset(ext_reset), .enable(enable), .pattern_sel(pattern_sel),
      .hsync(hsync), .vsync(vsync), .de(de), .r(r), .g(g), .b(b),
      .x(x), .y(y), .frame_start(frame_start), .frame_cnt(frame_cnt)
   );
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask
   task automatic push(input string nm, input int ex, input int ey, input int fc, input logic [23:0] c);
      sb.push_back('{12'(ex), 12'(ey), 8'(fc), c});
      sb_name.push_back(nm);
   endtask
   task automatic wait_line(input int line);
      int n = 0;
      while (!(de && y == 12'(line) && x == '0) && n < 2 * HT * VT) begin
         @(negedge clk_p);
         n++;
      end
      chk("wait line", 32'(de && y == 12'(line)), 1);
   endtask
   task automatic wait_fs(input string nm);
      int n = 0;
      do begin
         @(negedge clk_p);
         n++;
      end while (!frame_start && n < 2 * HT * VT);
      chk(nm, 32'(frame_start), 1);
   endtask
   // Monitor: pops the next expected pixel when the DUT presents it.
   always @(negedge clk_p) begin
      exp_t  e;
      string nm;
      if (sb.size() > 0 && de && x == sb[0].ex && y == sb[0].ey && frame_cnt == sb[0].fc) begin
         e  = sb.pop_front();
         nm = sb_name.pop_front();
         chk(nm, {8'h0, r, g, b}, {8'h0, e.rgb});
      end
   end
   initial begin
      int n, de_n, de_last, hs_first, hs_n, vs_n, fc_bad;
      logic [23:0] blank_rgb;
      blank_rgb = '1;
      repeat (3) @(negedge clk_p);
      chk("rst de", 32'(de), 0);
      chk("rst rgb", {8'h0, r, g, b}, 0);
      chk("rst hsync", 32'(hsync), 1);
      chk("rst vsync", 32'(vsync), 1);
      chk("rst frame_start", 32'(frame_start), 0);
      chk("rst frame_cnt", 32'(frame_cnt), 0);
      push("bars x0", 0, 0, 0, 24'hFFFFFF);
      push("bars x80", 80, 0, 0, 24'hFFFF00);
      push("bars x559", 559, 0, 0, 24'h0000FF);
      push("bars x560", 560, 0, 0, 24'h000000);
      ext_reset = 1'b1;
      @(negedge clk_p);
      enable = 1'b1;
      @(negedge clk_p);
      chk("start frame_start", 32'(frame_start), 1);
      chk("start x", 32'(x), 0);
      chk("start y", 32'(y), 0);
      chk("start de", 32'(de), 1);
      de_n = 0; de_last = -1; hs_first = -1; hs_n = 0;
      for (int c = 0; c < HT; c++) begin
         if (de) begin de_n++; de_last = c; end
         if (!hsync) begin
            if (hs_first < 0) hs_first = c;
            hs_n++;
         end
         if (c == 700) blank_rgb = {r, g, b};
         @(negedge clk_p);
      end
      chk("de cycles per line", 32'(de_n), HA);
      chk("de last cycle", 32'(de_last), HA - 1);
      chk("hsync start offset", 32'(hs_first), HA + HF);
      chk("hsync width", 32'(hs_n), HS);
      chk("blank rgb", {8'h0, blank_rgb}, 0);
      chk("line period x", 32'(x), 0);
      chk("line period y", 32'(y), 1);
      chk("line period de", 32'(de), 1);
      n = HT; vs_n = 0;
      while (!frame_start && n < 2 * HT * VT) begin
         if (!vsync) vs_n++;
         @(negedge clk_p);
         n++;
      end
      chk("frame cycles", 32'(n), HT * VT);
      chk("lines per frame", 32'(n / HT), VT);
      chk("vsync cycles", 32'(vs_n), HT);
      chk("frame_cnt after frame", 32'(frame_cnt), 1);
      push("keep bars x0", 0, 3, 1, 24'hFFFFFF);
      push("keep bars x85", 85, 3, 1, 24'hFFFF00);
      push("grad 200,1", 200, 1, 2, 24'hC801C9);
      push("grad 5,3", 5, 3, 2, 24'h050308);
      push("grid 33,0", 33, 0, 3, 24'hFFFFFF);
      push("grid 0,1", 0, 1, 3, 24'hFFFFFF);
      push("grid 32,1", 32, 1, 3, 24'hFFFFFF);
      push("grid 33,1", 33, 1, 3, 24'h000000);
      push("move fc4 x7", 7, 1, 4, 24'h000000);
      push("move fc4 x8", 8, 1, 4, MW);
      push("move fc4 x23", 23, 1, 4, MW);
      push("move fc4 x24", 24, 1, 4, 24'h000000);
      push("move fc5 x9", 9, 2, 5, 24'h000000);
      push("move fc5 x10", 10, 2, 5, MW);
      push("move fc5 x25", 25, 2, 5, MW);
      push("move fc5 x26", 26, 2, 5, 24'h000000);
      wait_line(2);
      pattern_sel = 2'd2;
      wait_fs("frame 2 start");
      pattern_sel = 2'd1;
      wait_fs("frame 3 start");
      pattern_sel = 2'd3;
      wait_fs("frame 4 start");
      wait_fs("frame 5 start");
      chk("frame_cnt at frame 5", 32'(frame_cnt), 5);
      wait_line(3);
      ext_reset = 1'b0;
      #1;
      chk("mid rst de", 32'(de), 0);
      chk("mid rst rgb", {8'h0, r, g, b}, 0);
      chk("mid rst hsync", 32'(hsync), 1);
      chk("mid rst frame_start", 32'(frame_start), 0);
      chk("mid rst frame_cnt", 32'(frame_cnt), 0);
      @(negedge clk_p);
      ext_reset = 1'b1;
      @(negedge clk_p);
      chk("post rst frame_start", 32'(frame_start), 1);
      chk("post rst x", 32'(x), 0);
      chk("post rst y", 32'(y), 0);
      @(negedge clk_p);
      chk("post rst pulse width", 32'(frame_start), 0);
      chk("post rst next x", 32'(x), 1);
      wait_fs("frame after reset");
      repeat (100) @(negedge clk_p);
      enable = 1'b0;
      @(negedge clk_p);
      de_n = 0; fc_bad = 0;
      for (int c = 0; c < 1000; c++) begin
         if (de) de_n++;
         if (frame_cnt != 8'd1) fc_bad++;
         @(negedge clk_p);
      end
      chk("idle de cycles", 32'(de_n), 0);
      chk("idle frame_cnt held", 32'(fc_bad), 0);
      chk("idle hsync", 32'(hsync), 1);
      chk("idle vsync", 32'(vsync), 1);
      chk("idle frame_start", 32'(frame_start), 0);
      enable = 1'b1;
      @(negedge clk_p);
      chk("reenable frame_start", 32'(frame_start), 1);
      chk("reenable x", 32'(x), 0);
      chk("reenable y", 32'(y), 0);
      chk("reenable frame_cnt", 32'(frame_cnt), 1);
      chk("scoreboard drained", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/video_pattern_gen.md
VIDEO_PATTERN_GEN -- requirements
Module: video_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line; must be a multiple of 8.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, the horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, the vertical equivalents in lines.
REQ-004 SHALL have parameters HS_POL 0 and VS_POL 0, the asserted sync level.
REQ-005 SHALL have ports:
- clk_p  in  1  pixel clock.
- ext_reset  in  1  asynchronous, active-low reset.
- enable  in  1  run timing; low = idle.
- pattern_sel  in  2  pattern request.
- hsync, vsync, de  out  1 each  registered video timing.
- r, g, b  out  8 each  registered pixel colour.
- x, y  out  12 each  active-area coordinates of the current pixel.
- frame_start  out  1  single-cycle pulse at pixel (0,0).
- frame_cnt  out  8  completed-frame counter.

Function
REQ-006 SHALL count hcnt 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters, and wrap to 0.
REQ-007 SHALL count vcnt 0..V_TOTAL-1, incrementing only on the hcnt wrap, and wrap to 0 on its own last line.
REQ-008 SHALL treat the active area as (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE); de=1 there, otherwise 0, and rgb=0 when de=0.
REQ-009 SHALL assert hsync (=HS_POL) for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, otherwise drive it to ~HS_POL.
REQ-010 SHALL assert vsync (=VS_POL) for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, for the whole line; the line boundary is set by hcnt.
REQ-011 SHALL register every output; the outputs in cycle n+1 reflect the counters in cycle n (latency 1), with all outputs aligned.
REQ-012 SHALL pulse frame_start for exactly one cycle, coincident with de for x=0, y=0.
REQ-013 SHALL increment frame_cnt (mod 256) at the vcnt wrap.
REQ-014 SHALL sample pattern_sel only at the vcnt wrap, and when leaving idle, so the pattern never changes mid-frame.
REQ-015 SHALL generate pattern 0 as colour bars: 8 bars each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black.
- Full-scale value = 8'hFF.
- Bar index comes from an incrementing bar counter, not a divider.
REQ-016 SHALL generate pattern 1 as a grid: white where x[4:0]==0 or y[4:0]==0, else black.
REQ-017 SHALL generate pattern 2 as a gradient: r=x[7:0], g=y[7:0], b=(x+y) truncated to 8 bits.
REQ-018 SHALL generate pattern 3 per REQ-024/REQ-025.
REQ-019 SHALL, when enable is low, synchronously clear the counters to 0 and hold the outputs at idle values.
- Idle = de 0, rgb 0, syncs deasserted, frame_start 0.
- frame_cnt is held, not cleared.
REQ-020 SHALL, on enable rising, start the first cycle at hcnt=vcnt=0, so frame_start appears one cycle after enable is seen high.

Reset
REQ-021 SHALL, while ext_reset=0, asynchronously force the counters to 0, frame_cnt to 0, the latched pattern to 0, and all outputs to the idle values of REQ-019.
REQ-022 SHALL, on ext_reset release mid-frame, restart at hcnt=vcnt=0; no partial-frame continuation.
REQ-023 SHALL deassert ext_reset in the clk_p domain synchronously; the block does not resynchronise it.

Configuration
REQ-024 SHALL, with VPG_MOVING_BAR_EN defined, render pattern 3 as a vertical white bar 16 pixels wide on black.
- Bar left edge = {frame_cnt,1'b0} mod H_ACTIVE.
REQ-025 SHALL, without VPG_MOVING_BAR_EN, render pattern 3 as solid black, with no bar logic synthesised.

Structure
REQ-026 SHALL place the pattern-code constants (PAT_BARS=0, PAT_GRID=1, PAT_GRAD=2, PAT_MOVE=3) and the 8-entry bar colour table in shared package video_pkg.
REQ-027 SHALL split the design into one sub-module, video_timing_core (counters, sync, de, x/y, frame_start), with pattern generation in the parent.

Verification
REQ-028 SHALL check timing with defaults, enable=1 after reset: de high for 640 consecutive cycles per line, hsync low for 96 cycles starting 656 cycles after de rises, 800 cycles per line, 525 lines per frame.
REQ-029 SHALL check pattern 0: at y=0, x=0 rgb=FFFFFF, x=80 rgb=FFFF00, x=559 rgb=0000FF, x=560 rgb=000000; de=0 gives rgb=000000.
REQ-030 SHALL check the mid-frame pattern change: change pattern_sel 0->2 at line 100; the frame keeps bars, and the next frame at (5,3) gives rgb=05,03,08.
REQ-031 SHALL check reset mid-frame: ext_reset low at line 200 gives immediate idle outputs and frame_cnt=0; after release, frame_start pulses 1 cycle later with x=0, y=0.
REQ-032 SHALL check enable: low for 1000 cycles gives de=0 throughout and frame_cnt held; re-enable gives frame_start on the next cycle.
REQ-033 SHALL check pattern 3 with VPG_MOVING_BAR_EN: at frame_cnt=5 white appears exactly for x=10..25; without the macro, rgb=0 everywhere.
